// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: channel width, default line length and
// the read-side state type of the line mirror.
package img_pkg;

  localparam int C_IMGDEPTH = 8;
  localparam int C_LINE_DEF = 1920;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/line_ram.sv
// One line bank: simple dual-port RAM with one write port and one
// synchronous read port. The read register only updates when re is high,
// so a stalled consumer can keep using rdata. Contents are never reset.
module line_ram #(
  parameter int P_IMGDEPTH = 8,
  parameter int P_DEPTH    = 1920,
  parameter int AW         = $clog2(P_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [P_IMGDEPTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [P_IMGDEPTH-1:0] rdata
);

  logic [P_IMGDEPTH-1:0] mem [P_DEPTH];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_mirror.sv
// Horizontal line mirror. Two ping-pong line banks: the write side fills one
// bank in ascending order while the read side empties the other in
// descending order. The read side issues RAM reads ahead of the output
// register (p1 = RAM read data, p2 = output register) so that a full-rate
// stream runs without bubbles, including across line boundaries.
module line_mirror
  import img_pkg::*;
#(
  parameter int P_IMGDEPTH = C_IMGDEPTH,
  parameter int P_LINE     = C_LINE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [P_IMGDEPTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [P_IMGDEPTH-1:0] out_data,
  output logic                  out_eol,
  input  logic                  out_ready
);

  localparam int            AW        = $clog2(P_LINE);
  localparam logic [AW-1:0] ADDR_LAST = AW'(P_LINE - 1);

  logic [1:0]            full;
  logic                  wr_bank;
  logic [AW-1:0]         wr_addr;
  logic                  rd_bank;
  logic [AW-1:0]         rd_addr;
  rd_state_e             rd_state;

  logic                  vld_p1;
  logic                  eol_p1;
  logic                  bank_p1;

  logic                  in_fire;
  logic                  wr_last;
  logic [1:0]            we;
  logic [1:0]            re;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;
  logic                  p2_free;
  logic                  p1_free;
  logic                  rd_issue;
  logic                  issue_last;
  logic [AW-1:0]         issue_addr;
  logic [P_IMGDEPTH-1:0] rdata [2];

  assign in_ready = !full[wr_bank];
  assign in_fire  = in_valid && in_ready;
  assign wr_last  = in_fire && (wr_addr == ADDR_LAST);

  // Handshake and read-issue decode; IDLE issues the first read of a line
  // directly so a ready bank starts streaming without a dead cycle
  always_comb begin
    p2_free    = !out_valid || out_ready;
    p1_free    = !vld_p1 || p2_free;
    rd_issue   = p1_free && ((rd_state == RD_READ) || full[rd_bank]);
    issue_addr = (rd_state == RD_IDLE) ? ADDR_LAST : rd_addr;
    issue_last = rd_issue && (issue_addr == '0);
    we         = {in_fire && wr_bank, in_fire && !wr_bank};
    re         = {rd_issue && rd_bank, rd_issue && !rd_bank};
    full_set   = {wr_last && wr_bank, wr_last && !wr_bank};
    full_clr   = {issue_last && rd_bank, issue_last && !rd_bank};
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    line_ram #(
      .P_IMGDEPTH(P_IMGDEPTH),
      .P_DEPTH   (P_LINE),
      .AW        (AW)
    ) u_ram (
      .clk  (clk),
      .we   (we[g]),
      .waddr(wr_addr),
      .wdata(in_data),
      .re   (re[g]),
      .raddr(issue_addr),
      .rdata(rdata[g])
    );
  end

  // Write side: ascending address, bank swap after the last pixel of a line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr <= '0;
      wr_bank <= 1'b0;
    end else if (in_fire) begin
      if (wr_last) begin
        wr_addr <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_addr <= wr_addr + AW'(1);
      end
    end
  end

  // Bank full flags: writer sets, reader clears; both may act in one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) full <= 2'b00;
    else      full <= (full | full_set) & ~full_clr;
  end

  // Read FSM: descending address, release the bank once address 0 is read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= RD_IDLE;
      rd_addr  <= '0;
      rd_bank  <= 1'b0;
    end else if (rd_issue) begin
      if (issue_last) begin
        rd_state <= RD_IDLE;
        rd_bank  <= !rd_bank;
      end else begin
        rd_state <= RD_READ;
        rd_addr  <= issue_addr - AW'(1);
      end
    end
  end

  // ---- stage p1: RAM read data valid ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      eol_p1  <= 1'b0;
      bank_p1 <= 1'b0;
    end else if (rd_issue) begin
      vld_p1  <= 1'b1;
      eol_p1  <= issue_last;
      bank_p1 <= rd_bank;
    end else if (p2_free) begin
      vld_p1  <= 1'b0;
    end
  end

  // ---- stage p2: registered outputs, held while downstream stalls ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_data  <= '0;
    end else if (p2_free) begin
      out_valid <= vld_p1;
      out_eol   <= vld_p1 && eol_p1;
      if (vld_p1) out_data <= rdata[bank_p1];
    end
  end

endmodule

// File: tb/tb_line_mirror.sv
// Self-checking bench for line_mirror with P_LINE=4. A negedge monitor keeps
// a reference model: every completed input line is reversed into an expected
// queue, and every output transfer is compared against it.
module tb_line_mirror;

  localparam int LINE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_eol;
  logic       out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int out_pos = 0;

  logic [7:0] line_buf[$];
  logic [7:0] exp_q[$];
  int         out_cyc[$];
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_eol = 1'b0;

  always #5 clk = ~clk;

  line_mirror #(
    .P_IMGDEPTH(8),
    .P_LINE    (LINE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_eol  (out_eol),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model and stall-stability monitor
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (!rst) begin
      line_buf.delete();
      exp_q.delete();
      out_pos    = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
        chk("hold_eol", out_eol, prev_eol);
      end
      if (in_valid && in_ready) begin
        line_buf.push_back(in_data);
        if (line_buf.size() == LINE) begin
          for (int k = LINE - 1; k >= 0; k--) exp_q.push_back(line_buf[k]);
          line_buf.delete();
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          chk("out_eol", out_eol, (out_pos == LINE - 1));
          out_pos = (out_pos + 1) % LINE;
        end
        out_cyc.push_back(cyc);
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_eol   = out_eol;
    end
  end

  // Downstream ready pattern: 0 stall, 1 always, 2 toggle, 3 random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Offer one pixel; in_valid stays high afterwards so back-to-back calls stream
  task automatic push_px(input logic [7:0] d, input int gap_pct, input int tmo, output bit ok);
    int t;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < tmo) begin
      @(negedge clk);
      t++;
    end
    ok = in_ready;
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input int gap_pct);
    bit ok;
    push_px(d, gap_pct, 500, ok);
    chk("push_accept", ok, 1'b1);
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0;
    rdy_mode = 1;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bit ok;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit ok;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_eol", out_eol, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single line 00..03, plus first-output latency
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) send(8'(i), 0);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency_ok", (n <= 4), 1'b1);
    chk("first_out", out_data, 8'h03);
    drain();

    // Two lines 10..17 back-to-back, no output gap
    out_cyc.delete();
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 0);
    in_valid = 1'b0;
    n = 0;
    while (out_cyc.size() < 8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("two_line_count", out_cyc.size(), 8);
    if (out_cyc.size() >= 8) chk("no_gap", out_cyc[7] - out_cyc[0], 7);
    drain();

    // Downstream stalled while three lines are offered
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 0);
    push_px(8'h28, 0, 10, ok);
    chk("px9_blocked", ok, 1'b0);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_head_valid", out_valid, 1'b1);
    chk("stall_head_data", out_data, 8'h23);
    rdy_mode = 1;
    for (int i = 8; i < 12; i++) send(8'h20 + 8'(i), 0);
    drain();

    // out_ready toggling every cycle
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) send(8'h30 + 8'(i), 0);
    drain();

    // Reset after two pixels of a line
    send(8'hB0, 0);
    send(8'hB1, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("postrst_out_valid", out_valid, 1'b0);
    chk("postrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("postrst_first", out_data, 8'hA3);
    drain();

    // 1000 random lines with random input gaps and random backpressure
    rdy_mode = 3;
    for (int l = 0; l < 1000; l++) begin
      for (int k = 0; k < LINE; k++) send(8'($urandom), 30);
    end
    drain();
    chk("partial_line_left", line_buf.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/line_mirror.md
LINE_MIRROR -- requirements
Module: line_mirror

Interface
REQ-001 Parameter P_IMGDEPTH, default 8, is the pixel bit width of one colour channel.
REQ-002 Parameter P_LINE, default 1920, is the number of pixels per image line; legal range is 2..4096.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: in_data holds a valid pixel.
REQ-006 Port in_data, input, P_IMGDEPTH bits: input pixel, in raster order.
REQ-007 Port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 Port out_valid, output, 1 bit: out_data holds a valid mirrored pixel.
REQ-009 Port out_data, output, P_IMGDEPTH bits: output pixel, in horizontally mirrored order.
REQ-010 Port out_eol, output, 1 bit: asserted with the last output pixel of each line.
REQ-011 Port out_ready, input, 1 bit: the downstream stage accepts out_data this cycle.

Function
REQ-012 The block shall reverse pixel order within each line of P_LINE pixels: input index k of a line is output at position P_LINE-1-k; line order is preserved.
REQ-013 An input transfer shall occur when in_valid and in_ready are both 1; an output transfer shall occur when out_valid and out_ready are both 1.
REQ-014 Storage shall be two line banks (ping-pong), each P_LINE words; the write side fills the bank selected by wr_bank at addresses 0..P_LINE-1 in ascending order.
REQ-015 On the input transfer at address P_LINE-1, the block shall set that bank's full flag, clear the write address to 0, and toggle wr_bank.
REQ-016 in_ready shall be 1 exactly when the full flag of the current wr_bank is 0.
REQ-017 The read side shall be a state machine with states IDLE and READ.
REQ-018 In IDLE, if the full flag of rd_bank is 1, the block shall load rd_addr = P_LINE-1 and move to READ.
REQ-019 In READ, rd_addr shall decrement on each output transfer; the transfer at address 0 shall assert out_eol, clear the full flag of that bank, toggle rd_bank, and return to IDLE.
REQ-020 out_data and out_valid shall be registered outputs.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_valid and out_eol shall hold stable.
REQ-022 With in_valid and out_ready held at 1, sustained throughput shall be one pixel per clock on both ports, with no bubbles between lines.
REQ-023 Latency: the first mirrored pixel of a line shall appear on out_valid no later than 3 cycles after the input transfer of that line's last pixel.
REQ-024 If the write side sets one bank full and the read side clears the other bank in the same cycle, both flag updates shall take effect.
REQ-025 If in_valid=1 while in_ready=0, the pixel shall not be written and no state shall change.
REQ-026 All address counters shall be ceil(log2(P_LINE)) bits wide and shall never leave the range 0..P_LINE-1.

Reset
REQ-027 While rst=0, the block shall set: out_valid=0, out_eol=0, out_data=0, both full flags=0, wr_bank=0, rd_bank=0, write address=0, read state=IDLE.
REQ-028 Asserting rst mid-line shall discard all buffered pixels; after reset is released, the next accepted pixel shall be index 0 of a new line.
REQ-029 Line-bank RAM contents shall not be reset.

Structure
REQ-030 The shared package img_pkg shall hold P_IMGDEPTH, the P_LINE default, and the read-state enum type.
REQ-031 Each bank shall be an instance of the sub-module line_ram: simple dual-port, one write port, one synchronous read port, depth P_LINE.

Verification (P_LINE=4, P_IMGDEPTH=8)
REQ-032 Input 00,01,02,03 back-to-back with out_ready=1 -> output 03,02,01,00; out_eol is asserted with 00.
REQ-033 Input 8 pixels 10..17 continuously with out_ready=1 -> output 13,12,11,10,17,16,15,14, with no gap between the two lines.
REQ-034 Hold out_ready=0 while 3 lines are offered -> in_ready drops after pixel 8 and pixel 9 is not accepted; when out_ready rises, lines 1 and 2 drain mirrored, and only then is line 3 accepted.
REQ-035 Toggle out_ready every cycle -> out_data is stable across every stall and no pixel is duplicated or lost.
REQ-036 Pulse rst low after 2 pixels of a line -> out_valid=0 and in_ready=1; the next 4 pixels A0..A3 emerge as A3,A2,A1,A0.
REQ-037 Drop in_valid randomly for 1000 lines of random data -> every output line matches the reference-model reversal.
